// File: rtl/pm32_pkg.sv
// pm32_pkg: definitions shared by the pm32 multiply-accumulate path.
//   - FSM state encoding for pm32_dot_acc
//   - default product / accumulator / count widths
//   - product typedef matching the pm32 multiplier output
package pm32_pkg;

  localparam int PM32_PROD_W = 64;
  localparam int PM32_ACC_W  = 72;
  localparam int PM32_LEN_W  = 8;

  typedef logic [PM32_PROD_W-1:0] pm32_prod_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pm32_dot_acc_if.sv
// pm32_dot_acc_if: product and result valid/ready handshakes.
//   prod_valid/prod/prod_ready : product stream from the multiplier
//   res_valid/res/res_ready    : accumulated sum to downstream
// master = producer of products / consumer of results, slave = accumulator.
interface pm32_dot_acc_if
  import pm32_pkg::*;
#(
  parameter int PROD_W = PM32_PROD_W,
  parameter int ACC_W  = PM32_ACC_W
) ();

  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res;

  modport master (
    output prod_valid, prod, res_ready,
    input  prod_ready, res_valid, res
  );

  modport slave (
    input  prod_valid, prod, res_ready,
    output prod_ready, res_valid, res
  );

endinterface

// File: rtl/pm32_dot_acc.sv
// pm32_dot_acc: sums a programmed number of unsigned products into a wide
// accumulator and presents the total over a valid/ready handshake.
//   clk, rst_n    : clock, async active-low reset
//   start, len    : begin a job of len products (sampled only in IDLE)
//   bus (slave)   : prod_valid/prod/prod_ready in, res_valid/res/res_ready out
//   busy          : not IDLE
//   overflow      : sticky carry-out of the accumulator for the current job
module pm32_dot_acc
  import pm32_pkg::*;
#(
  parameter int PROD_W = PM32_PROD_W,
  parameter int ACC_W  = PM32_ACC_W,
  parameter int LEN_W  = PM32_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  pm32_dot_acc_if.slave    bus,
  output logic             busy,
  output logic             overflow
);

  state_t             state, state_nx;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   cnt;
  logic               ovf;
  logic               beat;
  logic               last;
  logic [ACC_W:0]     sum;

  // Ready depends only on state, so a beat is just valid while in ACCUM.
  assign beat = (state == ST_ACCUM) && bus.prod_valid;
  assign last = (cnt == LEN_W'(1));
  // One extra bit captures the carry out of the accumulator.
  assign sum  = {1'b0, acc} + (ACC_W+1)'(bus.prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.prod_ready = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res        = '0;
    busy           = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (len == '0) ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        bus.prod_ready = 1'b1;
        if (beat && last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        bus.res_valid = 1'b1;
        bus.res       = acc;
        if (bus.res_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath: a start in IDLE clears the job; only beats update it afterwards,
  // so starts seen in ACCUM/DONE leave no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      acc <= '0;
      cnt <= len;
      ovf <= 1'b0;
    end else if (beat) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt - LEN_W'(1);
      if (sum[ACC_W]) ovf <= 1'b1;
    end
  end

  assign overflow = ovf;

endmodule

// File: tb/tb_pm32_dot_acc.sv
// tb_pm32_dot_acc: drives a 72-bit and a 64-bit accumulator build with the
// same stimulus and compares both against a wide-integer model of each job.
module tb_pm32_dot_acc;

  localparam logic [63:0] PMAX = 64'hFFFF_FFFE_0000_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        prod_valid;
  logic [63:0] prod;
  logic        res_ready;
  logic        busy72, ovf72, busy64, ovf64;

  int errs   = 0;
  int checks = 0;
  logic [63:0] pq[$];

  always #5 clk = ~clk;

  pm32_dot_acc_if #(.PROD_W(64), .ACC_W(72)) b72 ();
  pm32_dot_acc_if #(.PROD_W(64), .ACC_W(64)) b64 ();

  assign b72.prod_valid = prod_valid;
  assign b72.prod       = prod;
  assign b72.res_ready  = res_ready;
  assign b64.prod_valid = prod_valid;
  assign b64.prod       = prod;
  assign b64.res_ready  = res_ready;

  pm32_dot_acc #(.PROD_W(64), .ACC_W(72), .LEN_W(8)) u72 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .bus(b72), .busy(busy72), .overflow(ovf72)
  );

  pm32_dot_acc #(.PROD_W(64), .ACC_W(64), .LEN_W(8)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .bus(b64), .busy(busy64), .overflow(ovf64)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  {busy72, busy64}, 2'b00);
    chk({tag, "_rdy"},   {b72.prod_ready, b64.prod_ready}, 2'b00);
    chk({tag, "_rvld"},  {b72.res_valid, b64.res_valid}, 2'b00);
    chk({tag, "_res72"}, b72.res, 0);
    chk({tag, "_res64"}, b64.res, 0);
    chk({tag, "_ovf"},   {ovf72, ovf64}, 2'b00);
  endtask

  // One job of pq.size() products. gap<0 picks 0..2 idle cycles per beat,
  // bp is the number of cycles res_ready is held low, poke fires stray starts.
  task automatic do_job(input string tag, input int gap, input int bp, input bit poke);
    logic [127:0] tot;
    int n;
    n   = pq.size();
    tot = '0;
    start = 1'b1;
    len   = 8'(n);
    prod_valid = 1'($urandom_range(0, 1));
    prod  = {$urandom, $urandom};
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int k = 0; k < g; k++) begin
        prod_valid = 1'b0;
        prod  = {$urandom, $urandom};
        if (poke) begin start = 1'b1; len = 8'd5; end
        chk({tag, "_gap_rdy"}, {b72.prod_ready, b64.prod_ready}, 2'b11);
        tick();
        start = 1'b0;
      end
      chk({tag, "_rdy"},  {b72.prod_ready, b64.prod_ready}, 2'b11);
      chk({tag, "_rvld0"}, {b72.res_valid, b64.res_valid}, 2'b00);
      prod_valid = 1'b1;
      prod = pq[i];
      tot  = tot + 128'(pq[i]);
      tick();
    end
    // Offers in DONE must not be absorbed.
    prod_valid = 1'($urandom_range(0, 1));
    prod  = {$urandom, $urandom};
    res_ready = 1'b0;
    chk({tag, "_rvld"},  {b72.res_valid, b64.res_valid}, 2'b11);
    chk({tag, "_res72"}, b72.res, tot[71:0]);
    chk({tag, "_res64"}, b64.res, tot[63:0]);
    chk({tag, "_ovf72"}, ovf72, |tot[127:72]);
    chk({tag, "_ovf64"}, ovf64, |tot[127:64]);
    chk({tag, "_done_rdy"}, {b72.prod_ready, b64.prod_ready}, 2'b00);
    for (int k = 0; k < bp; k++) begin
      tick();
      prod_valid = 1'b1;
      chk({tag, "_hold_rvld"}, {b72.res_valid, b64.res_valid}, 2'b11);
      chk({tag, "_hold72"}, b72.res, tot[71:0]);
      chk({tag, "_hold64"}, b64.res, tot[63:0]);
      chk({tag, "_hold_rdy"}, {b72.prod_ready, b64.prod_ready}, 2'b00);
    end
    res_ready = 1'b1;
    tick();
    res_ready  = 1'b0;
    prod_valid = 1'b0;
    chk({tag, "_after_rvld"}, {b72.res_valid, b64.res_valid}, 2'b00);
    chk({tag, "_after_busy"}, {busy72, busy64}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0;
    prod_valid = 1'b0; prod = '0; res_ready = 1'b0;
    tick(); tick();
    chk_idle("rst");
    rst_n = 1'b1;
    tick();
    chk_idle("post_rst");

    pq = '{64'h2, 64'h4E20, 64'hFFFE0001};
    do_job("basic", 0, 0, 1'b0);

    pq = '{PMAX, PMAX};
    do_job("stall", 3, 5, 1'b0);

    // Follow-up job must clear the 64-bit build's sticky overflow.
    pq = '{64'h2, 64'h4E20, 64'hFFFE0001};
    do_job("ovf_clr", 0, 1, 1'b0);

    pq.delete();
    do_job("zero", 0, 2, 1'b0);

    pq = '{64'h11, 64'h22};
    do_job("busy_start", 1, 0, 1'b1);

    // Reset after 1 of 4 beats.
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod = 64'h1234;
    tick();
    prod_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_idle("midrst");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      prod_valid = 1'b1;
      prod = {$urandom, $urandom};
      tick();
      chk("midrst_norvld", {b72.res_valid, b64.res_valid, busy72, busy64}, 4'b0000);
    end
    prod_valid = 1'b0;
    pq = '{64'h7};
    do_job("fresh", 0, 0, 1'b0);

    pq.delete();
    for (int i = 0; i < 255; i++) pq.push_back(PMAX);
    do_job("max255", 0, 0, 1'b0);

    for (int j = 0; j < 20; j++) begin
      int n;
      n = $urandom_range(0, 12);
      pq.delete();
      for (int i = 0; i < n; i++) begin
        logic [63:0] a, b;
        a = 64'($urandom);
        b = 64'($urandom);
        pq.push_back(($urandom_range(0, 3) == 0) ? PMAX : a * b);
      end
      do_job("rand", -1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pm32_dot_acc.md
# pm32_dot_acc

Sequential accumulator stage directly downstream of the `pm32` 32×32 unsigned multiplier. It consumes a stream of 64-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator, forming an unsigned dot product. It presents the final sum over a second valid/ready handshake. Together with `pm32` it forms the multiply-accumulate path.

## Interface
- `PROD_W`, 64, product width; matches the `pm32` output `c`.
- `ACC_W`, 72, accumulator and result width; must be ≥ `PROD_W`.
- `LEN_W`, 8, width of the product-count field.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a new accumulation; ignored unless in IDLE.
- `len`  in  LEN_W  number of products to accumulate; sampled with `start`.
- `prod_valid`  in  1  product beat valid.
- `prod`  in  PROD_W  unsigned product.
- `prod_ready`  out  1  stage accepts a product this cycle.
- `res_valid`  out  1  result valid.
- `res`  out  ACC_W  accumulated sum.
- `res_ready`  in  1  downstream accepts result.
- `busy`  out  1  high in any state except IDLE.
- `overflow`  out  1  sticky carry-out of the accumulator for the current job.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE
  - `start`=1 and `len`≠0: clear acc, load counter with `len`, clear `overflow`, go to ACCUM.
  - `start`=1 and `len`=0: clear acc and `overflow`, go directly to DONE.
- ACCUM
  - `prod_ready`=1.
  - Each beat with `prod_valid && prod_ready` does: acc ← acc + zero_extend(`prod`); counter decrements.
  - A carry out of bit ACC_W-1 sets `overflow`; acc wraps modulo 2^ACC_W.
  - The beat that takes the counter 1→0 moves the FSM to DONE.
- DONE
  - `res_valid`=1 and `res`=acc, both held stable until `res_ready`=1.
  - On the handshake cycle, go to IDLE.
- `prod_ready`=0 in IDLE and DONE. Products offered outside ACCUM are not consumed.
- `start` in ACCUM or DONE is ignored, with no side effects.
- Arithmetic is unsigned only. With default widths, 255 products of (2^32−1)^2 cannot overflow.

## Timing
- Reset (asynchronous assert, synchronous deassert at the next edge):
  - state=IDLE, acc=0, counter=0.
  - `prod_ready`=0, `res_valid`=0, `res`=0, `busy`=0, `overflow`=0.
- `start` sampled at edge N puts the FSM in ACCUM at N+1; `prod_ready` is high from that cycle.
- Throughput is one product per cycle with no bubbles.
- Latency: the last product accepted at edge M gives `res_valid`=1 in cycle M+1.
- `len`=0: `res_valid`=1 in the cycle after `start`.
- Minimum job-to-job spacing: a new `start` is accepted one cycle after the result handshake.
- `rst_n` low mid-job aborts the job immediately. No result is produced and all outputs return to reset values.
- All outputs are registered or decoded from registered state. There is no combinational path from `prod_valid`/`res_ready` to `prod_ready`/`res_valid`.

## Structure
- A shared package `pm32_pkg` holds:
  - the FSM state enum (IDLE/ACCUM/DONE),
  - `PROD_W`/`ACC_W` defaults,
  - a product typedef shared with `pm32`.
- There are no sub-modules; the FSM, counter and adder live in one module.
- A top-level `pm32_mac` (out of scope here) instantiates `pm32` feeding `pm32_dot_acc`.

## Test plan
- **Basic three-product job.** Apply `len`=3 and products 0x2, 0x4E20, 0xFFFE0001, all back-to-back.
  - Required: `res`=0xFFFE4E23 and `overflow`=0.
  - Required: `res_valid` rises 1 cycle after the third beat.
- **Stalls and backpressure.** Apply `len`=2 with product 0xFFFFFFFE00000001 twice, a 3-cycle `prod_valid` gap between beats, and `res_ready` held low 5 cycles.
  - Required: `res`=0x1_FFFFFFFC_00000002, held stable for all 5 cycles.
  - Required: `prod_ready`=0 throughout DONE.
- **Zero-length job.** Apply `len`=0 with `start`.
  - Required: `res_valid`=1 the next cycle with `res`=0.
  - Required: no product consumed even though `prod_valid`=1.
- **Overflow, narrow accumulator.** Build with `ACC_W`=64 and apply `len`=2 with product 0xFFFFFFFE00000001 twice.
  - Required: `overflow`=1 and `res`=0xFFFFFFFC00000002.
  - Required: the next job clears `overflow`.
- **Start while busy.** Pulse `start` with `len`=5 during an ACCUM of `len`=2.
  - Required: it is ignored and the result is produced after exactly 2 beats.
- **Reset mid-job.** Assert `rst_n`=0 after 1 of 4 beats.
  - Required: outputs are at reset values immediately, and no `res_valid` follows.
  - Required: a fresh `len`=1 job with product 0x7 returns `res`=0x7.
